regfile_sequencer: RTL and testbench

- Command-driven controller for the 8-register file (T1..T4, R1..R4): accepts one register-file command at a time and sequences it into per-cycle FunSel, RSel, TSel, O1Sel, O2Sel and data-in drives.
- Sits between the control unit and the register file; the register file's O1/O2 outputs return to this block for move/swap operations.

---
 rtl/regfile_sequencer.sv | 160 ++++++++++++++++
 tb/tb_regfile_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sequencer.sv
// Command sequencer for the 8-register file: turns one accepted command into
// per-cycle FunSel / RSel / TSel / O1Sel / O2Sel / data-in drives.
module regfile_sequencer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [2:0]       cmd_dst,
  input  logic [2:0]       cmd_src,
  input  logic [WIDTH-1:0] cmd_imm,
  input  logic [CNT_W-1:0] cmd_cnt,
  input  logic [WIDTH-1:0] rf_o1,
  input  logic [WIDTH-1:0] rf_o2,
  output logic [1:0]       rf_funsel,
  output logic [3:0]       rf_rsel,
  output logic [3:0]       rf_tsel,
  output logic [2:0]       rf_o1sel,
  output logic [2:0]       rf_o2sel,
  output logic [WIDTH-1:0] rf_i,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] OP_NOP    = 3'b000;
  localparam logic [2:0] OP_CLR    = 3'b001;
  localparam logic [2:0] OP_LDI    = 3'b010;
  localparam logic [2:0] OP_MOV    = 3'b011;
  localparam logic [2:0] OP_INC    = 3'b100;
  localparam logic [2:0] OP_DEC    = 3'b101;
  localparam logic [2:0] OP_SWAP   = 3'b110;
  localparam logic [2:0] OP_CLRALL = 3'b111;

  localparam logic [1:0] FS_DEC  = 2'b00;
  localparam logic [1:0] FS_INC  = 2'b01;
  localparam logic [1:0] FS_LOAD = 2'b10;
  localparam logic [1:0] FS_CLR  = 2'b11;

  typedef enum logic [2:0] {IDLE, READ, WRITE, WRITE2, STEP, DONE} state_t;

  state_t           state, state_nx;
  logic [2:0]       op_q, dst_q, src_q;
  logic [WIDTH-1:0] imm_q, hold_a, hold_b;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       o1sel_q, o2sel_q;
  logic [7:0]       en;
  logic             accept;

  // Index 0-3 selects T1..T4, 4-7 selects R1..R4; MSB of each group is the
  // lowest-numbered register. Returned as {rsel, tsel}.
  function automatic logic [7:0] enable_of(input logic [2:0] idx);
    logic [7:0] e;
    e = '0;
    if (idx[2]) e[7:4] = 4'b1000 >> idx[1:0];
    else        e[3:0] = 4'b1000 >> idx[1:0];
    return e;
  endfunction

  assign cmd_ready = (state == IDLE);
  assign accept    = cmd_valid & cmd_ready;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign {rf_rsel, rf_tsel} = en;
  // Selects follow the latched indices while reading and hold afterwards.
  assign rf_o1sel  = (state == READ) ? src_q : o1sel_q;
  assign rf_o2sel  = (state == READ) ? dst_q : o2sel_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      op_q    <= '0;
      dst_q   <= '0;
      src_q   <= '0;
      imm_q   <= '0;
      cnt_q   <= '0;
      hold_a  <= '0;
      hold_b  <= '0;
      o1sel_q <= '0;
      o2sel_q <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        op_q  <= cmd_op;
        dst_q <= cmd_dst;
        src_q <= cmd_src;
        imm_q <= cmd_imm;
        cnt_q <= cmd_cnt;
      end else if (state == STEP) begin
        cnt_q <= cnt_q - 1'b1;
      end
      if (state == READ) begin
        hold_a  <= rf_o1;
        hold_b  <= rf_o2;
        o1sel_q <= src_q;
        o2sel_q <= dst_q;
      end
    end
  end

  always_comb begin
    state_nx  = state;
    rf_funsel = FS_DEC;
    rf_i      = '0;
    en        = '0;
    case (state)
      IDLE: begin
        if (accept) begin
          case (cmd_op)
            OP_CLR, OP_LDI, OP_CLRALL: state_nx = WRITE;
            OP_MOV, OP_SWAP:           state_nx = READ;
            OP_INC, OP_DEC:            state_nx = (cmd_cnt != '0) ? STEP : DONE;
            default:                   state_nx = DONE;
          endcase
        end
      end
      READ: state_nx = WRITE;
      WRITE: begin
        case (op_q)
          OP_CLR: begin
            rf_funsel = FS_CLR;
            en        = enable_of(dst_q);
          end
          OP_CLRALL: begin
            rf_funsel = FS_CLR;
            en        = 8'hFF;
          end
          OP_LDI: begin
            rf_funsel = FS_LOAD;
            rf_i      = imm_q;
            en        = enable_of(dst_q);
          end
          default: begin
            rf_funsel = FS_LOAD;
            rf_i      = hold_a;
            en        = enable_of(dst_q);
          end
        endcase
        state_nx = (op_q == OP_SWAP) ? WRITE2 : DONE;
      end
      WRITE2: begin
        rf_funsel = FS_LOAD;
        rf_i      = hold_b;
        en        = enable_of(src_q);
        state_nx  = DONE;
      end
      STEP: begin
        rf_funsel = (op_q == OP_INC) ? FS_INC : FS_DEC;
        en        = enable_of(dst_q);
        // Counter still holds the remaining steps including this one.
        if (cnt_q <= 1) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed bench for regfile_sequencer: a register-file model answers O1/O2,
// a command-level model predicts every cycle's drives and the final contents.
module tb_regfile_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op, cmd_dst, cmd_src;
  logic [7:0] cmd_imm;
  logic [3:0] cmd_cnt;
  logic [7:0] rf_o1, rf_o2;
  logic [1:0] rf_funsel;
  logic [3:0] rf_rsel, rf_tsel;
  logic [2:0] rf_o1sel, rf_o2sel;
  logic [7:0] rf_i;
  logic       busy, done;

  regfile_sequencer #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_dst(cmd_dst), .cmd_src(cmd_src),
    .cmd_imm(cmd_imm), .cmd_cnt(cmd_cnt),
    .rf_o1(rf_o1), .rf_o2(rf_o2),
    .rf_funsel(rf_funsel), .rf_rsel(rf_rsel), .rf_tsel(rf_tsel),
    .rf_o1sel(rf_o1sel), .rf_o2sel(rf_o2sel), .rf_i(rf_i),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  localparam logic [2:0] NOP = 3'd0, CLR = 3'd1, LDI = 3'd2, MOV = 3'd3,
                         INC = 3'd4, DEC = 3'd5, SWAP = 3'd6, CLRALL = 3'd7;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Register file model driven by the DUT's enables.
  logic [7:0] regs [8];
  assign rf_o1 = regs[rf_o1sel];
  assign rf_o2 = regs[rf_o2sel];

  always @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if ((i < 4) ? rf_tsel[3-i] : rf_rsel[7-i]) begin
        case (rf_funsel)
          2'b00: regs[i] <= regs[i] - 8'd1;
          2'b01: regs[i] <= regs[i] + 8'd1;
          2'b10: regs[i] <= rf_i;
          default: regs[i] <= 8'd0;
        endcase
      end
    end
  end

  // Command-level expectation: register contents and per-cycle drive trace.
  logic [7:0] exp_regs [8] = '{default: 8'd0};

  typedef struct {
    logic       rdy, bsy, dn;
    logic [1:0] fs;
    logic [7:0] en;     // {rsel, tsel}
    logic [7:0] ri;
    logic       selchk;
    logic [2:0] s1, s2;
  } exp_t;

  exp_t q[$];
  logic chk_en = 1'b0;

  function automatic logic [7:0] onehot(input int idx);
    logic [7:0] e;
    e = 8'd0;
    e[(idx < 4) ? (3 - idx) : (7 - (idx - 4) + 0)] = 1'b1;
    return e;
  endfunction

  task automatic push(input logic [1:0] fs, input logic [7:0] en, input logic [7:0] ri,
                      input logic dn, input logic selchk, input logic [2:0] s1, input logic [2:0] s2);
    exp_t e;
    e.rdy = 1'b0; e.bsy = 1'b1; e.dn = dn; e.fs = fs; e.en = en; e.ri = ri;
    e.selchk = selchk; e.s1 = s1; e.s2 = s2;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      exp_t e;
      if (q.size() > 0) e = q.pop_front();
      else begin
        e.rdy = 1'b1; e.bsy = 1'b0; e.dn = 1'b0; e.fs = 2'b00; e.en = 8'd0;
        e.ri = 8'd0; e.selchk = 1'b0; e.s1 = 3'd0; e.s2 = 3'd0;
      end
      check("cycle {ready,busy,done,funsel,rsel,tsel,rf_i}",
            {11'd0, cmd_ready, busy, done, rf_funsel, rf_rsel, rf_tsel, rf_i},
            {11'd0, e.rdy, e.bsy, e.dn, e.fs, e.en, e.ri});
      if (e.selchk)
        check("read {o1sel,o2sel}", {26'd0, rf_o1sel, rf_o2sel}, {26'd0, e.s1, e.s2});
    end
  end

  task automatic issue(input logic [2:0] op, input int dst, input int src,
                       input logic [7:0] imm, input int cnt);
    int guard;
    logic [7:0] a, b;
    guard = 0;
    @(negedge clk);
    while (!cmd_ready && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 60) check("ready timeout", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_op = op; cmd_dst = 3'(dst); cmd_src = 3'(src); cmd_imm = imm; cmd_cnt = 4'(cnt);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    case (op)
      NOP: ;
      CLR: begin
        push(2'b11, onehot(dst), 8'd0, 1'b0, 1'b0, 3'd0, 3'd0);
        exp_regs[dst] = 8'd0;
      end
      CLRALL: begin
        push(2'b11, 8'hFF, 8'd0, 1'b0, 1'b0, 3'd0, 3'd0);
        for (int i = 0; i < 8; i++) exp_regs[i] = 8'd0;
      end
      LDI: begin
        push(2'b10, onehot(dst), imm, 1'b0, 1'b0, 3'd0, 3'd0);
        exp_regs[dst] = imm;
      end
      MOV, SWAP: begin
        a = exp_regs[src];
        b = exp_regs[dst];
        push(2'b00, 8'd0, 8'd0, 1'b0, 1'b1, 3'(src), 3'(dst));
        push(2'b10, onehot(dst), a, 1'b0, 1'b0, 3'd0, 3'd0);
        exp_regs[dst] = a;
        if (op == SWAP) begin
          push(2'b10, onehot(src), b, 1'b0, 1'b0, 3'd0, 3'd0);
          exp_regs[src] = b;
        end
      end
      default: begin
        for (int k = 0; k < cnt; k++)
          push((op == INC) ? 2'b01 : 2'b00, onehot(dst), 8'd0, 1'b0, 1'b0, 3'd0, 3'd0);
        exp_regs[dst] = (op == INC) ? exp_regs[dst] + 8'(cnt) : exp_regs[dst] - 8'(cnt);
      end
    endcase
    push(2'b00, 8'd0, 8'd0, 1'b1, 1'b0, 3'd0, 3'd0);
  endtask

  task automatic wait_done();
    int guard;
    guard = 0;
    while (q.size() != 0 && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 60) check("done timeout", 32'(q.size()), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0;
    cmd_op = 3'd0; cmd_dst = 3'd0; cmd_src = 3'd0; cmd_imm = 8'd0; cmd_cnt = 4'd0;
    #12;
    check("reset {ready,busy,done}", {29'd0, cmd_ready, busy, done}, 32'b100);
    check("reset drives", {13'd0, rf_funsel, rf_rsel, rf_tsel, rf_i}, 32'd0);
    check("reset selects", {26'd0, rf_o1sel, rf_o2sel}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;

    issue(LDI, 5, 0, 8'h3C, 0);
    wait_done();
    check("LDI R2 model", {24'd0, exp_regs[5]}, 32'h3C);
    check("LDI R2 regfile", {24'd0, regs[5]}, 32'h3C);

    issue(MOV, 0, 5, 8'h00, 0);
    wait_done();
    check("MOV R2->T1", {24'd0, regs[0]}, 32'h3C);

    issue(LDI, 4, 0, 8'h11, 0);
    issue(LDI, 7, 0, 8'hA5, 0);
    issue(SWAP, 7, 4, 8'h00, 0);
    wait_done();
    check("SWAP R4", {24'd0, regs[7]}, 32'h11);
    check("SWAP R1", {24'd0, regs[4]}, 32'hA5);

    issue(LDI, 3, 0, 8'hFE, 0);
    issue(INC, 3, 0, 8'h00, 3);
    wait_done();
    check("INC T4 wrap", {24'd0, regs[3]}, 32'h01);
    issue(INC, 3, 0, 8'h00, 0);
    wait_done();
    check("INC cnt0 T4", {24'd0, regs[3]}, 32'h01);

    // cmd_valid stays high while busy; the second CLRALL must wait for IDLE.
    issue(CLRALL, 0, 0, 8'h00, 0);
    cmd_valid = 1'b1;
    issue(CLRALL, 0, 0, 8'h00, 0);
    wait_done();
    check("CLRALL T1", {24'd0, regs[0]}, 32'h00);

    // Abort DEC cnt=5 on R3 during its second STEP; one decrement has landed.
    issue(DEC, 6, 0, 8'h00, 5);
    @(posedge clk);
    #2;
    chk_en = 1'b0;
    q.delete();
    rst_n = 1'b0;
    #1;
    check("abort enables", {24'd0, rf_rsel, rf_tsel}, 32'd0);
    check("abort {ready,busy,done}", {29'd0, cmd_ready, busy, done}, 32'b100);
    repeat (3) begin
      @(negedge clk);
      check("abort no done", {31'd0, done}, 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("post-abort {ready,busy}", {30'd0, cmd_ready, busy}, 32'b10);
    check("abort R3", {24'd0, regs[6]}, 32'hFF);
    exp_regs[6] = 8'hFF;
    chk_en = 1'b1;

    issue(LDI, 1, 0, 8'h80, 0);
    issue(DEC, 1, 0, 8'h00, 2);
    issue(MOV, 1, 1, 8'h00, 0);
    issue(SWAP, 1, 1, 8'h00, 0);
    wait_done();
    check("DEC/self-move T2", {24'd0, regs[1]}, 32'h7E);
    issue(CLR, 6, 0, 8'h00, 0);
    issue(NOP, 0, 0, 8'h00, 0);
    issue(LDI, 2, 0, 8'h5A, 0);
    issue(MOV, 5, 2, 8'h00, 0);
    wait_done();
    @(negedge clk);

    for (int i = 0; i < 8; i++)
      check($sformatf("final reg %0d", i), {24'd0, regs[i]}, {24'd0, exp_regs[i]});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
